// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: EX/D-stage forwarding selects,
// load-use / branch / MDU stall generation, MDU busy counter and one-deep WD tracker.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic       UseRs_D,
  input  logic       UseRt_D,
  input  logic       Branch_D,
  input  logic       MduUse_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WRegADD_E,
  input  logic       RegWrite_E,
  input  logic       MemToReg_E,
  input  logic [4:0] WRegADD_M,
  input  logic       RegWrite_M,
  input  logic       MemToReg_M,
  input  logic [4:0] WRegADD_W,
  input  logic       RegWrite_W,
  input  logic       MduStart_E,
  input  logic       MduIsDiv_E,
  output logic [1:0] ForwardRSE,
  output logic [1:0] ForwardRTE,
  output logic       ForwardRSD,
  output logic       ForwardRTD,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Flush_E,
  output logic       MduBusy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] FWD_RD  = 2'b00;
  localparam logic [1:0] FWD_M   = 2'b01;
  localparam logic [1:0] FWD_W   = 2'b10;
  localparam logic [1:0] FWD_WD  = 2'b11;

  logic [CNT_W-1:0] cnt;
  logic             wd_valid;
  logic [4:0]       wd_addr;

  logic stall_lw;
  logic stall_br;
  logic stall_mdu;
  logic stall;

  // A stage hits register r when it writes r and r is not $0.
  function automatic logic stage_hit(input logic we, input logic [4:0] wa, input logic [4:0] r);
    return we && (wa == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    logic [1:0] sel;
    sel = FWD_RD;
    if (stage_hit(RegWrite_M, WRegADD_M, r) && !MemToReg_M)
      sel = FWD_M;
    else if (stage_hit(RegWrite_W, WRegADD_W, r))
      sel = FWD_W;
    else if (stage_hit(wd_valid, wd_addr, r))
      sel = FWD_WD;
    return sel;
  endfunction

  always_comb begin
    ForwardRSE = fwd_sel(Rs_E);
    ForwardRTE = fwd_sel(Rt_E);
  end

  // Branch operands only forward from M when M holds an ALU result, not a pending load.
  always_comb begin
    ForwardRSD = Branch_D && !MemToReg_M && stage_hit(RegWrite_M, WRegADD_M, Rs_D);
    ForwardRTD = Branch_D && !MemToReg_M && stage_hit(RegWrite_M, WRegADD_M, Rt_D);
  end

  assign MduBusy = (cnt != '0);

  always_comb begin
    stall_lw  = MemToReg_E &&
                ((UseRs_D && stage_hit(RegWrite_E, WRegADD_E, Rs_D)) ||
                 (UseRt_D && stage_hit(RegWrite_E, WRegADD_E, Rt_D)));
    stall_br  = Branch_D &&
                (stage_hit(RegWrite_E, WRegADD_E, Rs_D) ||
                 stage_hit(RegWrite_E, WRegADD_E, Rt_D) ||
                 (MemToReg_M && (stage_hit(RegWrite_M, WRegADD_M, Rs_D) ||
                                 stage_hit(RegWrite_M, WRegADD_M, Rt_D))));
    stall_mdu = MduUse_D && (MduBusy || MduStart_E);
    stall     = stall_lw || stall_br || stall_mdu;
  end

  assign Stall_F = stall;
  assign Stall_D = stall;
  assign Flush_E = stall;

  // A new start always reloads the counter, even while a previous operation is still running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (MduStart_E) begin
      cnt <= MduIsDiv_E ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_valid <= 1'b0;
      wd_addr  <= 5'd0;
    end else begin
      wd_valid <= RegWrite_W && (WRegADD_W != 5'd0);
      wd_addr  <= WRegADD_W;
    end
  end

endmodule
